// File: rtl/mem_axi_pkg.sv
// Shared types and constants for the AXI3-style read-only memory responder.
package mem_axi_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned LEN_W  = 4;

    localparam logic [2:0] SIZE_8B     = 3'b011;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } state_e;

    // One R-channel beat as held in the output register.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_beat_t;

    // WRAP bursts must cover a power-of-two number of beats.
    function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/mem_axi_rd_addr_gen.sv
// Combinational beat-address generator: word address of beat idx, plus burst legality.
module mem_axi_rd_addr_gen
    import mem_axi_pkg::*;
#(
    parameter int unsigned WORD_W = 13
) (
    input  logic [WORD_W-1:0] start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [1:0]        burst_i,
    input  logic [LEN_W-1:0]  idx_i,
    output logic [WORD_W-1:0] addr_c,
    output logic              legal_c
);

    logic [WORD_W-1:0] sum;
    logic [WORD_W-1:0] mask;

    assign sum  = start_i + WORD_W'(idx_i);
    assign mask = WORD_W'(len_i);

    // Select beat address by burst type; reserved type is flagged illegal.
    always_comb begin
        addr_c  = start_i;
        legal_c = 1'b1;
        case (burst_i)
            BURST_FIXED: addr_c = start_i;
            BURST_INCR:  addr_c = sum;
            BURST_WRAP: begin
                addr_c  = (start_i & ~mask) | (sum & mask);
                legal_c = wrap_len_ok(len_i);
            end
            default:     legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_axi_rd_responder.sv
// Read-only AXI3-style memory responder: one burst at a time, programmable first-beat latency.
module mem_axi_rd_responder
    import mem_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   arid_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [3:0]            arlen_i,
    input  logic [2:0]            arsize_i,
    input  logic [1:0]            arburst_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic [63:0]           rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [31:0]           wr_data_i
);

    localparam int unsigned WORD_W   = ADDR_WIDTH - 3;
    localparam int unsigned DEPTH    = 1 << WORD_W;
    localparam logic [3:0]  LAT_LAST = 4'((RD_LATENCY == 0) ? 0 : RD_LATENCY - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [WORD_W-1:0]   start_q, start_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic                err_q, err_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rvalid_q, rvalid_d;
    logic                arready_q, arready_d;
    r_beat_t             beat_q, beat_d;

    logic [WORD_W-1:0]   gen_start;
    logic [LEN_W-1:0]    gen_len;
    logic [1:0]          gen_burst;
    logic [LEN_W-1:0]    gen_idx;
    logic [WORD_W-1:0]   gen_addr;
    logic                gen_legal;
    r_beat_t             next_beat;
    logic                ar_hs;
    logic                unused_bits;

    assign unused_bits = ^{wr_addr_i[2:0], araddr_i[2:0]};

    // While idle the generator checks the incoming request; otherwise it addresses the latched burst.
    assign gen_start = (state_q == ST_IDLE) ? araddr_i[ADDR_WIDTH-1:3] : start_q;
    assign gen_len   = (state_q == ST_IDLE) ? arlen_i : len_q;
    assign gen_burst = (state_q == ST_IDLE) ? arburst_i : burst_q;
    assign gen_idx   = (state_q == ST_IDLE) ? '0 : idx_q;

    mem_axi_rd_addr_gen #(
        .WORD_W (WORD_W)
    ) u_addr_gen (
        .start_i (gen_start),
        .len_i   (gen_len),
        .burst_i (gen_burst),
        .idx_i   (gen_idx),
        .addr_c  (gen_addr),
        .legal_c (gen_legal)
    );

    assign ar_hs = arvalid_i && arready_q;

    // Beat that would be loaded this cycle; errored bursts return zero data.
    always_comb begin
        next_beat.data = err_q ? '0 : mem[gen_addr];
        next_beat.resp = err_q ? RESP_SLVERR : RESP_OKAY;
        next_beat.last = (idx_q == len_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        start_d   = start_q;
        len_d     = len_q;
        burst_d   = burst_q;
        err_d     = err_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rvalid_d  = rvalid_q;
        arready_d = arready_q;
        beat_d    = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    id_d      = arid_i;
                    start_d   = araddr_i[ADDR_WIDTH-1:3];
                    len_d     = arlen_i;
                    burst_d   = arburst_i;
                    err_d     = !gen_legal || (arsize_i != SIZE_8B);
                    idx_d     = '0;
                    cnt_d     = '0;
                    arready_d = 1'b0;
                    state_d   = (RD_LATENCY == 0) ? ST_DATA : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DATA: begin
                if (!rvalid_q || (rready_i && !beat_q.last)) begin
                    beat_d   = next_beat;
                    rvalid_d = 1'b1;
                    idx_d    = idx_q + 4'd1;
                end else if (rready_i) begin
                    rvalid_d    = 1'b0;
                    beat_d.last = 1'b0;
                    arready_d   = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            start_q   <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            start_q   <= start_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
            beat_q    <= beat_d;
        end
    end

    // Backdoor preload: one 32-bit half of a 64-bit word per edge.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            if (wr_addr_i[2]) begin
                mem[wr_addr_i[ADDR_WIDTH-1:3]][63:32] <= wr_data_i;
            end else begin
                mem[wr_addr_i[ADDR_WIDTH-1:3]][31:0] <= wr_data_i;
            end
        end
    end

    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rid_o     = id_q;
    assign rdata_o   = beat_q.data;
    assign rresp_o   = beat_q.resp;
    assign rlast_o   = beat_q.last;

endmodule

// File: doc/mem_axi_rd_responder.md
Name: mem_axi_rd_responder

Overview:
Synthesizable AXI3-style read-only memory responder for the cache controller's memory-side AR/R port, replacing the behavioural memory model in system-level runs. It accepts one read burst at a time and returns 64-bit beats from an internal 2^ADDR_WIDTH-byte array after a programmable latency. INCR, WRAP and FIXED bursts are supported, so critical-word-first line fills work. A 32-bit backdoor write port preloads the array.

Parameters:
ADDR_WIDTH, 16, byte-address width; array holds 2^ADDR_WIDTH bytes as 2^(ADDR_WIDTH-3) 64-bit words
ID_WIDTH, 4, AXI ID width
RD_LATENCY, 2, idle cycles between AR handshake and first rvalid (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
arid_i  in  ID_WIDTH  request ID
araddr_i  in  ADDR_WIDTH  start byte address
arlen_i  in  4  beats minus one
arsize_i  in  3  beat size; only 3'b011 (8 B) is legal
arburst_i  in  2  0 FIXED, 1 INCR, 2 WRAP
arvalid_i  in  1  request valid
arready_o  out  1  request accept
rid_o  out  ID_WIDTH  echoed arid
rdata_o  out  64  beat data
rresp_o  out  2  0 OKAY, 2 SLVERR
rlast_o  out  1  final beat
rvalid_o  out  1  beat valid
rready_i  in  1  beat accept
wr_en_i  in  1  backdoor write strobe
wr_addr_i  in  ADDR_WIDTH  byte address of a 32-bit word; bits [1:0] ignored
wr_data_i  in  32  backdoor write data

Behaviour:
- Reset (rst_n=1, asynchronous): state IDLE; arready_o=1; rvalid_o=0, rlast_o=0, rresp_o=0, rid_o=0, rdata_o=0. Array contents are not reset. Reset mid-burst aborts the burst with no further beats.
- FSM states:
  - IDLE: arready_o=1. AR handshake at edge T latches id, addr[ADDR_WIDTH-1:3], len, burst, and an error flag. At T+1: arready_o=0; go to WAIT, or directly to DATA if RD_LATENCY=0.
  - WAIT: counts RD_LATENCY cycles. The first beat has rvalid_o=1 from T+1+RD_LATENCY.
  - DATA: rvalid_o stays high until rready_i. On handshake of a non-last beat, the next beat is presented the following cycle with no bubble. On handshake with rlast_o=1, the next cycle is IDLE with rvalid_o=0 and arready_o=1.
- Beat addressing (word units, beat index i=0..len):
  - INCR: start+i, wrapping modulo array size.
  - FIXED: start for every beat.
  - WRAP: mask=len, legal only for len in {1,3,7,15}; addr_i = (start & ~mask) | ((start+i) & mask). Example: len=7, start word 5 gives words 5,6,7,0,1,2,3,4 of the aligned 64 B line.
- rdata_o = {mem[byte+4..+7], mem[byte..+3]}, little-endian, registered when each beat is loaded.
- araddr_i[2:0] are ignored.
- rlast_o=1 only on beat len. rid_o is constant across the burst.
- Error: if arsize_i≠3, arburst_i=3, or WRAP with an illegal len, every beat carries rresp_o=2 and rdata_o=0, with full beat count and normal rlast_o.
- Backdoor write: wr_en_i writes one 32-bit half-word-of-64 at the next edge; it is legal in any state. If a write and a beat load hit the same word on the same edge, the beat returns the old data.
- rready_i held low: rvalid_o, rdata_o, rlast_o, rresp_o and rid_o are stable indefinitely.
- arvalid_i while busy: ignored (arready_o=0); the request is accepted on return to IDLE.

Decomposition:
- Package mem_axi_pkg: burst type enum (FIXED/INCR/WRAP), RESP_OKAY/RESP_SLVERR constants, SIZE_8B constant, FSM state enum.
- Sub-module mem_axi_rd_addr_gen: combinational beat-address generator (start, len, burst, index → word address, legal flag).
- Storage stays an inferred array inside the top module.

Test Plan:
- Preload word pairs 0x1000→0x11111111 and 0x1004→0x22222222; INCR len=0 at 0x1000, RD_LATENCY=2 → single beat 0x22222222_11111111 with rlast=1, rresp=0, rvalid exactly 3 cycles after the AR handshake.
- WRAP len=7 at 0x0068 with arid=5 → 8 beats from words 0x0068,0x0070,0x0078,0x0040,…,0x0060; rid=5 on every beat; rlast only on beat 7; arready=1 the cycle after the last handshake.
- INCR len=3, rready toggled 1,0,0,1,… → data, rlast and rresp stable while stalled; 4 beats in order; no duplicate or dropped beats.
- arsize=2, len=3 → 4 beats with rresp=2, rdata=0, rlast on beat 3; the next legal request returns OKAY.
- Backdoor write to 0x0080 on the same edge the beat for 0x0080 loads → old data returned; re-read → new data.
- Assert rst_n during beat 2 of an 8-beat burst → rvalid=0 and arready=1 immediately; a new request after deassertion completes normally.
